// File: rtl/ysyx_23060184_axi_arbiter_pkg.sv
// Shared defines for the two-master AXI-lite arbiter: bus widths, master
// indices and the arbiter FSM encoding.
package ysyx_23060184_axi_arbiter_pkg;

    localparam int NUM_ARB_MASTERS = 2;
    localparam int DATA_WIDTH      = 32;
    localparam int ACERR_WIDTH     = 2;
    localparam int WMASK_LENGTH    = 4;

    localparam int IFU = 0;
    localparam int LSU = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ysyx_23060184_axi_arbiter_rr_select.sv
// Combinational round-robin picker: scans the request vector starting just
// after the last owner and returns a one-hot pick (all-zero when nobody asks).
module ysyx_23060184_rr_select #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] last,
    output logic [N-1:0]     gnt
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = PTR_W'((int'(last) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_23060184_axi_arbiter.sv
// Two-master AXI-lite arbiter (IFU / LSU) onto one shared slave port; one
// outstanding transaction at a time, round-robin between masters.
module ysyx_23060184_axi_arbiter #(
    parameter int NUM_ARB_MASTERS = ysyx_23060184_axi_arbiter_pkg::NUM_ARB_MASTERS,
    parameter int DATA_WIDTH      = ysyx_23060184_axi_arbiter_pkg::DATA_WIDTH,
    parameter int ACERR_WIDTH     = ysyx_23060184_axi_arbiter_pkg::ACERR_WIDTH,
    parameter int WMASK_LENGTH    = ysyx_23060184_axi_arbiter_pkg::WMASK_LENGTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [DATA_WIDTH-1:0]      m0_araddr,
    input  logic                       m0_arvalid,
    output logic                       m0_arready,
    output logic [DATA_WIDTH-1:0]      m0_rdata,
    output logic [ACERR_WIDTH-1:0]     m0_rresp,
    output logic                       m0_rvalid,
    input  logic                       m0_rready,
    input  logic [DATA_WIDTH-1:0]      m0_awaddr,
    input  logic                       m0_awvalid,
    output logic                       m0_awready,
    input  logic [DATA_WIDTH-1:0]      m0_wdata,
    input  logic [WMASK_LENGTH-1:0]    m0_wstrb,
    input  logic                       m0_wvalid,
    output logic                       m0_wready,
    output logic [ACERR_WIDTH-1:0]     m0_bresp,
    output logic                       m0_bvalid,
    input  logic                       m0_bready,
    input  logic [DATA_WIDTH-1:0]      m1_araddr,
    input  logic                       m1_arvalid,
    output logic                       m1_arready,
    output logic [DATA_WIDTH-1:0]      m1_rdata,
    output logic [ACERR_WIDTH-1:0]     m1_rresp,
    output logic                       m1_rvalid,
    input  logic                       m1_rready,
    input  logic [DATA_WIDTH-1:0]      m1_awaddr,
    input  logic                       m1_awvalid,
    output logic                       m1_awready,
    input  logic [DATA_WIDTH-1:0]      m1_wdata,
    input  logic [WMASK_LENGTH-1:0]    m1_wstrb,
    input  logic                       m1_wvalid,
    output logic                       m1_wready,
    output logic [ACERR_WIDTH-1:0]     m1_bresp,
    output logic                       m1_bvalid,
    input  logic                       m1_bready,
    output logic [DATA_WIDTH-1:0]      s_araddr,
    output logic                       s_arvalid,
    input  logic                       s_arready,
    input  logic [DATA_WIDTH-1:0]      s_rdata,
    input  logic [ACERR_WIDTH-1:0]     s_rresp,
    input  logic                       s_rvalid,
    output logic                       s_rready,
    output logic [DATA_WIDTH-1:0]      s_awaddr,
    output logic                       s_awvalid,
    input  logic                       s_awready,
    output logic [DATA_WIDTH-1:0]      s_wdata,
    output logic [WMASK_LENGTH-1:0]    s_wstrb,
    output logic                       s_wvalid,
    input  logic                       s_wready,
    input  logic [ACERR_WIDTH-1:0]     s_bresp,
    input  logic                       s_bvalid,
    output logic                       s_bready,
    output logic [NUM_ARB_MASTERS-1:0] grant
);
    import ysyx_23060184_axi_arbiter_pkg::*;

    localparam int PTR_W = (NUM_ARB_MASTERS > 1) ? $clog2(NUM_ARB_MASTERS) : 1;

    arb_state_e                 state_q, state_n;
    logic [NUM_ARB_MASTERS-1:0] grant_n, pick;
    logic [PTR_W-1:0]           ptr_q, ptr_n, pick_idx;

    logic [NUM_ARB_MASTERS-1:0] ar_req, wr_req, req, r_ready, b_ready;
    logic [NUM_ARB_MASTERS-1:0] arready_v, rvalid_v, awready_v, wready_v, bvalid_v;

    assign ar_req[IFU]  = m0_arvalid;
    assign ar_req[LSU]  = m1_arvalid;
    assign wr_req[IFU]  = m0_awvalid & m0_wvalid;
    assign wr_req[LSU]  = m1_awvalid & m1_wvalid;
    assign req          = ar_req | wr_req;
    assign r_ready[IFU] = m0_rready;
    assign r_ready[LSU] = m1_rready;
    assign b_ready[IFU] = m0_bready;
    assign b_ready[LSU] = m1_bready;

    ysyx_23060184_rr_select #(
        .N     (NUM_ARB_MASTERS),
        .PTR_W (PTR_W)
    ) u_rr_select (
        .req  (req),
        .last (ptr_q),
        .gnt  (pick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant   <= '0;
            ptr_q   <= PTR_W'(LSU);
        end else begin
            state_q <= state_n;
            grant   <= grant_n;
            ptr_q   <= ptr_n;
        end
    end

    // A master asking for both read and write is granted its read first.
    always_comb begin
        state_n  = state_q;
        grant_n  = grant;
        ptr_n    = ptr_q;
        pick_idx = '0;
        for (int i = 0; i < NUM_ARB_MASTERS; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_n = pick;
                    ptr_n   = pick_idx;
                    state_n = (|(pick & ar_req)) ? RD : WR;
                end
            end
            RD: begin
                if (s_rvalid && |(r_ready & grant)) begin
                    state_n = IDLE;
                    grant_n = '0;
                end
            end
            WR: begin
                if (s_bvalid && |(b_ready & grant)) begin
                    state_n = IDLE;
                    grant_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_comb begin
        arready_v = '0;
        rvalid_v  = '0;
        awready_v = '0;
        wready_v  = '0;
        bvalid_v  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        case (state_q)
            RD: begin
                s_arvalid = |(ar_req & grant);
                s_rready  = |(r_ready & grant);
                arready_v = grant & {NUM_ARB_MASTERS{s_arready}};
                rvalid_v  = grant & {NUM_ARB_MASTERS{s_rvalid}};
            end
            WR: begin
                s_awvalid = grant[IFU] ? m0_awvalid : m1_awvalid;
                s_wvalid  = grant[IFU] ? m0_wvalid  : m1_wvalid;
                s_bready  = |(b_ready & grant);
                awready_v = grant & {NUM_ARB_MASTERS{s_awready}};
                wready_v  = grant & {NUM_ARB_MASTERS{s_wready}};
                bvalid_v  = grant & {NUM_ARB_MASTERS{s_bvalid}};
            end
            default: ;
        endcase
    end

    // Payloads are steered by grant (or broadcast); only the handshakes are gated.
    assign s_araddr   = grant[LSU] ? m1_araddr : m0_araddr;
    assign s_awaddr   = grant[LSU] ? m1_awaddr : m0_awaddr;
    assign s_wdata    = grant[LSU] ? m1_wdata  : m0_wdata;
    assign s_wstrb    = grant[LSU] ? m1_wstrb  : m0_wstrb;

    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;
    assign m0_rresp   = s_rresp;
    assign m1_rresp   = s_rresp;
    assign m0_bresp   = s_bresp;
    assign m1_bresp   = s_bresp;

    assign m0_arready = arready_v[IFU];
    assign m1_arready = arready_v[LSU];
    assign m0_rvalid  = rvalid_v[IFU];
    assign m1_rvalid  = rvalid_v[LSU];
    assign m0_awready = awready_v[IFU];
    assign m1_awready = awready_v[LSU];
    assign m0_wready  = wready_v[IFU];
    assign m1_wready  = wready_v[LSU];
    assign m0_bvalid  = bvalid_v[IFU];
    assign m1_bvalid  = bvalid_v[LSU];

endmodule

// File: doc/ysyx_23060184_axi_arbiter.md
YSYX_23060184_AXI_ARBITER -- requirements
Module: ysyx_23060184_axi_arbiter

Interface
REQ-001 Parameter NUM_ARB_MASTERS, default 2, number of requesters; index 0 = IFU, index 1 = LSU.
REQ-002 Parameter DATA_WIDTH, default 32, address and data width.
REQ-003 Parameter ACERR_WIDTH, default 2, AXI resp width; WMASK_LENGTH, default 4, wstrb width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk, input, 1, rising-edge clock.
REQ-005 rstn, input, 1, asynchronous active-low reset.
REQ-006 mN_araddr / mN_arvalid: input, DATA_WIDTH / 1, per-master read address channel; mN_arready: output, 1.
REQ-007 mN_rdata / mN_rresp / mN_rvalid: output, DATA_WIDTH / ACERR_WIDTH / 1; mN_rready: input, 1.
REQ-008 mN_awaddr / mN_awvalid / mN_wdata / mN_wstrb / mN_wvalid: input, DATA_WIDTH / 1 / DATA_WIDTH / WMASK_LENGTH / 1; mN_awready / mN_wready: output, 1.
REQ-009 mN_bresp / mN_bvalid: output, ACERR_WIDTH / 1; mN_bready: input, 1.
REQ-010 s_* ports: the same five channels toward the shared slave, directions mirrored.
REQ-011 grant: output, NUM_ARB_MASTERS, one-hot owner of the slave port, all-zero when idle.

Function
REQ-012 FSM states: IDLE, RD, WR. Reset state is IDLE.
REQ-013 A master requests when arvalid=1 or (awvalid=1 and wvalid=1).
REQ-014 In IDLE with any request, the block SHALL register grant and enter RD (arvalid requester) or WR on the next edge. When one master requests both read and write, read wins.
REQ-015 Selection SHALL be round-robin: on a tie, the master not granted last wins. The last-owner pointer resets to 1, so m0 wins the first tie.
REQ-016 In RD/WR, only the granted master's channels are forwarded combinationally to s_*. Non-granted masters see arready=awready=wready=rvalid=bvalid=0. The s_* valid outputs are 0 in IDLE.
REQ-017 RD exits to IDLE on the edge where s_rvalid & granted rready; WR exits on s_bvalid & granted bready. grant clears on that same edge.
REQ-018 Every transaction is followed by at least one IDLE cycle, which gives a minimum of 3 cycles from request to the next grant.
REQ-019 Grant is never revoked mid-transaction. A requester that drops valid before its handshake keeps the grant until its response completes.
REQ-020 rresp and bresp, including error codes, pass through unmodified; the arbiter does not retry.
REQ-021 Slave responses arriving in IDLE are ignored: s_rready=s_bready=0 in IDLE.

Reset
REQ-022 On rstn=0, immediately: state IDLE, grant 0, pointer 1, and all output valid/ready signals 0, including mid-transaction.
REQ-023 After rstn deasserts, arbitration resumes on the first clk edge with a request.

Structure
REQ-024 FSM state encodings and the master index constants (IFU=0, LSU=1) SHALL live in the shared defines package alongside NUM_ARB_MASTERS, DATA_WIDTH, ACERR_WIDTH and WMASK_LENGTH.
REQ-025 One sub-module: ysyx_23060184_rr_select, a combinational round-robin picker (request vector + pointer -> one-hot).

Verification
REQ-026 Single read: m0 reads 0x80000000, slave returns 0x12345678 after 2 cycles -> grant=01, m0_rdata=0x12345678, then grant=00 for 1 cycle.
REQ-027 Tie: m0 read and m1 write arrive in the same cycle after reset -> m0 served first; m1 gets grant=10 immediately after the IDLE gap.
REQ-028 Fairness: m0 and m1 request reads back-to-back for 6 transactions -> grants alternate 01,10,01,10,01,10.
REQ-029 Error path: m1 write of 0xdeadbeef with wstrb=0xF, slave bresp=2'b10 -> m1_bresp=2'b10, bvalid reaches only m1.
REQ-030 Reset mid-RD: assert rstn=0 while m0 waits for rvalid -> grant=00 and s_arvalid=0 immediately; after release, a new m1 request is granted normally.
REQ-031 Stall: m0 holds rready=0 for 5 cycles with s_rvalid=1 -> grant stays 01 and m1's request waits.
